// File: rtl/rx_frame_err_filter.sv
// rtl/rx_frame_err_filter.sv - store-and-forward rx frame filter dropping crc-errored, oversize and link-aborted frames
//
// Purpose:
//   Buffers each incoming frame in full and releases it downstream only when
//   no beat carried the crcerr flag and the whole frame fitted in the buffer.
//   Errored, overflowing and link-down-cut frames are discarded and counted.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_stream_port_link/_speed    link status and speed code from the rate limiter
//   i_stream_port_axi_data       input beat data, top bit is the crcerr flag
//   i_stream_axi_data_keep/_valid/_last   input beat qualifiers
//   o_stream_port_ready          input accept, high whenever out of reset
//   o_filt_port_link/_speed      link and speed delayed by one register
//   o_filt_port_axi_data         output beat data, top bit always 0
//   o_filt_axi_data_keep/_valid/_last     output beat qualifiers
//   i_filt_port_ready            downstream ready
//   o_crc_drop_cnt               saturating count of frames dropped for crcerr
//   o_ovf_drop_cnt               saturating count of frames dropped for overflow or link-down

module rx_frame_err_filter #(
   parameter int PORT_NUM            = 4,
   parameter int PORT_MNG_DATA_WIDTH = 8,
   parameter int CROSS_DATA_WIDTH    = PORT_MNG_DATA_WIDTH * PORT_NUM,
   parameter int FIFO_DEPTH          = 512
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_stream_port_link,
   input  logic [1:0]                    i_stream_port_speed,
   input  logic [CROSS_DATA_WIDTH:0]     i_stream_port_axi_data,
   input  logic [CROSS_DATA_WIDTH/8-1:0] i_stream_axi_data_keep,
   input  logic                          i_stream_axi_data_valid,
   input  logic                          i_stream_axi_data_last,
   output logic                          o_stream_port_ready,
   output logic                          o_filt_port_link,
   output logic [1:0]                    o_filt_port_speed,
   output logic [CROSS_DATA_WIDTH:0]     o_filt_port_axi_data,
   output logic [CROSS_DATA_WIDTH/8-1:0] o_filt_axi_data_keep,
   output logic                          o_filt_axi_data_valid,
   output logic                          o_filt_axi_data_last,
   input  logic                          i_filt_port_ready,
   output logic [15:0]                   o_crc_drop_cnt,
   output logic [15:0]                   o_ovf_drop_cnt
);

   localparam int DW = CROSS_DATA_WIDTH;
   localparam int KW = CROSS_DATA_WIDTH / 8;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DW + KW + 1;
   localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITE   = 2'd1,
      ST_DISCARD = 2'd2
   } wr_state_e;

   // Buffer entry layout: {last, keep, data}; the crcerr bit is never stored.
   logic [EW-1:0] mem_q [FIFO_DEPTH];

   wr_state_e     state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   commit_ptr_q, commit_ptr_d;
   logic [AW:0]   rd_ptr_q;
   logic          err_q, err_d;
   logic          ready_q;
   logic          link_q;
   logic [1:0]    speed_q;
   logic [DW-1:0] out_data_q;
   logic [KW-1:0] out_keep_q;
   logic          out_last_q;
   logic          out_valid_q;
   logic [15:0]   crc_cnt_q;
   logic [15:0]   ovf_cnt_q;

   logic          mem_we;
   logic          crc_inc;
   logic          ovf_inc;
   logic          beat;
   logic          full;
   logic          beat_crc;
   logic          err_any;
   logic          has_data;
   logic          out_load;
   logic [EW-1:0] rd_entry;

   // Beats are only taken once ready is up, so the edge right after reset
   // release never writes.
   assign beat     = i_stream_axi_data_valid && ready_q;
   assign beat_crc = i_stream_port_axi_data[DW];
   assign err_any  = err_q || beat_crc;
   // Full counts uncommitted beats too, so an oversize frame can never
   // deadlock the buffer: it runs into full and is discarded.
   assign full     = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
   assign has_data = (rd_ptr_q != commit_ptr_q);
   assign out_load = has_data && (!out_valid_q || i_filt_port_ready);
   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

   // ------------------------------------------------------------------
   // Write-side FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      err_d        = err_q;
      mem_we       = 1'b0;
      crc_inc      = 1'b0;
      ovf_inc      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (beat && i_stream_port_link) begin
               if (full) begin
                  if (i_stream_axi_data_last) begin
                     wr_ptr_d = commit_ptr_q;
                     ovf_inc  = 1'b1;
                  end else begin
                     state_d = ST_DISCARD;
                  end
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  err_d    = beat_crc;
                  if (i_stream_axi_data_last) begin
                     // Single-beat frame: commit or drop right away.
                     if (!beat_crc) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                     end else begin
                        wr_ptr_d = commit_ptr_q;
                        crc_inc  = 1'b1;
                     end
                  end else begin
                     state_d = ST_WRITE;
                  end
               end
            end
         end

         ST_WRITE: begin
            // Link-down wins over any beat presented on the same cycle.
            if (!i_stream_port_link) begin
               wr_ptr_d = commit_ptr_q;
               ovf_inc  = 1'b1;
               state_d  = ST_IDLE;
            end else if (beat) begin
               if (full) begin
                  if (i_stream_axi_data_last) begin
                     wr_ptr_d = commit_ptr_q;
                     ovf_inc  = 1'b1;
                     state_d  = ST_IDLE;
                  end else begin
                     state_d = ST_DISCARD;
                  end
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  err_d    = err_any;
                  if (i_stream_axi_data_last) begin
                     if (!err_any) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                     end else begin
                        wr_ptr_d = commit_ptr_q;
                        crc_inc  = 1'b1;
                     end
                     state_d = ST_IDLE;
                  end
               end
            end
         end

         ST_DISCARD: begin
            if (!i_stream_port_link || (beat && i_stream_axi_data_last)) begin
               wr_ptr_d = commit_ptr_q;
               ovf_inc  = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            wr_ptr_d = commit_ptr_q;
         end
      endcase
   end

   // Buffer storage has no reset; pointers alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {i_stream_axi_data_last,
                                     i_stream_axi_data_keep,
                                     i_stream_port_axi_data[DW-1:0]};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         err_q        <= 1'b0;
         ready_q      <= 1'b0;
         link_q       <= 1'b0;
         speed_q      <= 2'b00;
         crc_cnt_q    <= 16'd0;
         ovf_cnt_q    <= 16'd0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         err_q        <= err_d;
         ready_q      <= 1'b1;
         link_q       <= i_stream_port_link;
         speed_q      <= i_stream_port_speed;
         if (crc_inc && (crc_cnt_q != 16'hFFFF)) begin
            crc_cnt_q <= crc_cnt_q + 16'd1;
         end
         if (ovf_inc && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read side: single output register fed from committed data only.
   // Uses the registered commit pointer, so a frame committed on edge N
   // presents its first beat after edge N+1.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rd_ptr_q    <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_load) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            out_data_q  <= rd_entry[DW-1:0];
            out_keep_q  <= rd_entry[DW +: KW];
            out_last_q  <= rd_entry[EW-1];
            out_valid_q <= 1'b1;
         end else if (i_filt_port_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign o_stream_port_ready   = ready_q;
   assign o_filt_port_link      = link_q;
   assign o_filt_port_speed     = speed_q;
   assign o_filt_port_axi_data  = {1'b0, out_data_q};
   assign o_filt_axi_data_keep  = out_keep_q;
   assign o_filt_axi_data_valid = out_valid_q;
   assign o_filt_axi_data_last  = out_last_q;
   assign o_crc_drop_cnt        = crc_cnt_q;
   assign o_ovf_drop_cnt        = ovf_cnt_q;

endmodule

// File: tb/tb_rx_frame_err_filter.sv
// tb/tb_rx_frame_err_filter.sv - directed table-driven bench for rx_frame_err_filter

module tb_rx_frame_err_filter;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic          clk;
   logic          rst_n;
   logic          in_link;
   logic [1:0]    in_speed;
   logic [DW:0]   in_data;
   logic [KW-1:0] in_keep;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic          o_ready;
   logic          o_link;
   logic [1:0]    o_speed;
   logic [DW:0]   o_data;
   logic [KW-1:0] o_keep;
   logic          o_valid;
   logic          o_last;
   logic [15:0]   o_crc;
   logic [15:0]   o_ovf;

   rx_frame_err_filter #(
      .PORT_NUM            (4),
      .PORT_MNG_DATA_WIDTH (8),
      .FIFO_DEPTH          (16)
   ) dut (
      .i_clk                   (clk),
      .i_rst                   (rst_n),
      .i_stream_port_link      (in_link),
      .i_stream_port_speed     (in_speed),
      .i_stream_port_axi_data  (in_data),
      .i_stream_axi_data_keep  (in_keep),
      .i_stream_axi_data_valid (in_valid),
      .i_stream_axi_data_last  (in_last),
      .o_stream_port_ready     (o_ready),
      .o_filt_port_link        (o_link),
      .o_filt_port_speed       (o_speed),
      .o_filt_port_axi_data    (o_data),
      .o_filt_axi_data_keep    (o_keep),
      .o_filt_axi_data_valid   (o_valid),
      .o_filt_axi_data_last    (o_last),
      .i_filt_port_ready       (in_ready),
      .o_crc_drop_cnt          (o_crc),
      .o_ovf_drop_cnt          (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        link;
      logic        valid;
      logic        last;
      logic        crc;
      logic [31:0] data;
      logic [3:0]  keep;
      logic        e_valid;
      logic [31:0] e_data;
      logic [3:0]  e_keep;
      logic        e_last;
      logic [15:0] e_crc;
   } vec_t;

   localparam int NV = 17;
   vec_t vt [NV];

   int n_vec = 0;
   int n_err = 0;

   logic [37:0] exp_q [$];
   logic        hold_pend = 1'b0;
   logic [37:0] held = '0;
   logic        tog_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sv(input int i, input bit lk, input bit v, input bit l, input bit c,
                     input logic [31:0] d, input logic [3:0] k, input bit ev,
                     input logic [31:0] ed, input logic [3:0] ek, input bit el,
                     input logic [15:0] ec);
      vt[i].link = lk;  vt[i].valid = v;  vt[i].last = l;  vt[i].crc = c;
      vt[i].data = d;   vt[i].keep = k;   vt[i].e_valid = ev;
      vt[i].e_data = ed; vt[i].e_keep = ek; vt[i].e_last = el; vt[i].e_crc = ec;
   endtask

   // Output-side checker, called at the falling edge: values seen here are
   // exactly what the next rising edge will hand over.
   task automatic mon_check();
      logic [37:0] cur;
      cur = {o_last, o_keep, o_data};
      if (hold_pend) chk("hold_stable", {o_valid, cur}, {1'b1, held});
      if (o_valid && in_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", cur);
         end else begin
            chk("out_beat", cur, exp_q.pop_front());
         end
      end
      hold_pend = o_valid && !in_ready;
      held      = cur;
   endtask

   // One clock: check outputs, take the edge, then update inputs at +2.
   task automatic cycle();
      @(negedge clk);
      mon_check();
      @(posedge clk);
      #2;
      if (tog_en) in_ready = ~in_ready;
   endtask

   task automatic send_frame(input int n, input logic [31:0] base, input int crc_beat,
                             input int drop_beat, input bit good);
      for (int b = 0; b < n; b++) begin
         in_valid = 1'b1;
         in_last  = (b == n - 1) || (b == drop_beat);
         in_keep  = (b == n - 1) ? 4'h7 : 4'hF;
         in_data  = {(b == crc_beat), base + 32'(b)};
         in_link  = (b != drop_beat);
         if (good) exp_q.push_back({in_last, in_keep, 1'b0, base + 32'(b)});
         cycle();
         if (b == drop_beat) break;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_link  = 1'b1;
   endtask

   task automatic drain(input int budget, input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         cycle();
         k++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      in_link  = 1'b0;
      in_speed = 2'b00;
      in_data  = '0;
      in_keep  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_ready = 1'b1;

      // Frame A: good 4 beats; frame B: crcerr on beat 2; frame C: good 2 beats.
      sv( 0, H, H, L, L, 32'hA000_0000, 4'hF, L, 32'h0,          4'h0, L, 16'd0);
      sv( 1, H, H, L, L, 32'hA000_0001, 4'hF, L, 32'h0,          4'h0, L, 16'd0);
      sv( 2, H, H, L, L, 32'hA000_0002, 4'hF, L, 32'h0,          4'h0, L, 16'd0);
      sv( 3, H, H, H, L, 32'hA000_0003, 4'h3, L, 32'h0,          4'h0, L, 16'd0);
      sv( 4, H, L, L, L, 32'h0,         4'h0, H, 32'hA000_0000, 4'hF, L, 16'd0);
      sv( 5, H, L, L, L, 32'h0,         4'h0, H, 32'hA000_0001, 4'hF, L, 16'd0);
      sv( 6, H, L, L, L, 32'h0,         4'h0, H, 32'hA000_0002, 4'hF, L, 16'd0);
      sv( 7, H, H, L, L, 32'hB000_0000, 4'hF, H, 32'hA000_0003, 4'h3, H, 16'd0);
      sv( 8, H, H, L, H, 32'hB000_0001, 4'hF, L, 32'h0,          4'h0, L, 16'd0);
      sv( 9, H, H, L, L, 32'hB000_0002, 4'hF, L, 32'h0,          4'h0, L, 16'd0);
      sv(10, H, H, H, L, 32'hB000_0003, 4'hF, L, 32'h0,          4'h0, L, 16'd1);
      sv(11, H, H, L, L, 32'hC000_0000, 4'hF, L, 32'h0,          4'h0, L, 16'd1);
      sv(12, H, H, H, L, 32'hC000_0001, 4'h1, L, 32'h0,          4'h0, L, 16'd1);
      sv(13, H, L, L, L, 32'h0,         4'h0, H, 32'hC000_0000, 4'hF, L, 16'd1);
      sv(14, H, L, L, L, 32'h0,         4'h0, H, 32'hC000_0001, 4'h1, H, 16'd1);
      sv(15, H, L, L, L, 32'h0,         4'h0, L, 32'h0,          4'h0, L, 16'd1);
      sv(16, L, L, L, L, 32'h0,         4'h0, L, 32'h0,          4'h0, L, 16'd1);

      // Reset state
      in_link  = 1'b1;
      in_speed = 2'b10;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_link",  o_link, 0);
      chk("rst_speed", o_speed, 0);
      chk("rst_cnts",  {o_crc, o_ovf}, 0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_up", o_ready, 1);
      #1;

      // Table phase: inputs applied at +2, outputs checked at +1 after the edge.
      for (int i = 0; i < NV; i++) begin
         in_link  = vt[i].link;
         in_valid = vt[i].valid;
         in_last  = vt[i].last;
         in_keep  = vt[i].keep;
         in_data  = {vt[i].crc, vt[i].data};
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), o_valid, vt[i].e_valid);
         if (vt[i].e_valid) begin
            chk($sformatf("v%0d_data", i), o_data, {1'b0, vt[i].e_data});
            chk($sformatf("v%0d_keep", i), o_keep, vt[i].e_keep);
            chk($sformatf("v%0d_last", i), o_last, vt[i].e_last);
         end
         chk($sformatf("v%0d_crc_cnt", i), o_crc, vt[i].e_crc);
         chk($sformatf("v%0d_ovf_cnt", i), o_ovf, 0);
         chk($sformatf("v%0d_link_spd", i), {o_link, o_speed}, {vt[i].link, 2'b10});
         #1;
      end
      in_link  = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      cycle();

      // Oversize frame with downstream stalled, then a good frame drains.
      in_ready = 1'b0;
      send_frame(20, 32'hD000_0000, -1, -1, 1'b0);
      chk("ovf_cnt_1", o_ovf, 1);
      chk("ovf_no_out", o_valid, 0);
      in_ready = 1'b1;
      send_frame(3, 32'hE000_0000, -1, -1, 1'b1);
      drain(40, "drain_after_ovf");

      // Good frame, then a frame cut by link-down on its third beat.
      send_frame(3, 32'h1000_0000, -1, -1, 1'b1);
      send_frame(5, 32'h2000_0000, -1, 2, 1'b0);
      drain(40, "drain_link_down");
      chk("ovf_cnt_2", o_ovf, 2);

      // Three back-to-back frames with ready toggling every cycle.
      tog_en = 1'b1;
      send_frame(3, 32'h3000_0000, -1, -1, 1'b1);
      send_frame(2, 32'h4000_0000, -1, -1, 1'b1);
      send_frame(4, 32'h5000_0000, -1, -1, 1'b1);
      drain(100, "drain_toggle");
      tog_en   = 1'b0;
      in_ready = 1'b1;
      cycle();
      cycle();
      chk("cnts_before_rst", {o_crc, o_ovf}, {16'd1, 16'd2});

      // Reset asserted during beat 2 of a frame.
      in_valid = 1'b1; in_last = 1'b0; in_keep = 4'hF; in_data = {1'b0, 32'h6000_0000};
      cycle();
      in_data = {1'b0, 32'h6000_0001};
      cycle();
      in_data = {1'b0, 32'h6000_0002};
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", o_ready, 0);
      chk("midrst_out", {o_valid, o_last, o_keep, o_data}, 0);
      chk("midrst_link_spd", {o_link, o_speed}, 0);
      chk("midrst_cnts", {o_crc, o_ovf}, 0);
      in_valid  = 1'b0;
      hold_pend = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      cycle();
      send_frame(2, 32'h7000_0000, -1, -1, 1'b1);
      drain(40, "drain_after_rst");
      chk("cnts_after_rst", {o_crc, o_ovf}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rx_frame_err_filter.md
# rx_frame_err_filter

Store-and-forward frame filter directly downstream of the per-port rate limiter in the rx port-management path. It buffers each complete frame, then releases it only if the crcerr flag was never set on any beat and the frame fitted in the buffer. Frames that are errored, overflowing or cut by link-down are discarded and counted. The output is a clean, error-free stream toward the switching core.

## Interface
Parameters:
- PORT_NUM, 4, switch port count
- PORT_MNG_DATA_WIDTH, 8, per-port data width
- CROSS_DATA_WIDTH, PORT_MNG_DATA_WIDTH*PORT_NUM, aggregated data width (DW)
- FIFO_DEPTH, 512, buffer depth in beats; power of 2, ≥ 4; AW = log2(FIFO_DEPTH)

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  asynchronous, active-low reset
- i_stream_port_link  in  1  link status from rate limiter
- i_stream_port_speed  in  2  speed code
- i_stream_port_axi_data  in  DW+1  data; bit DW = crcerr
- i_stream_axi_data_keep  in  DW/8  byte-valid mask
- i_stream_axi_data_valid  in  1  beat valid
- i_stream_axi_data_last  in  1  last beat of frame
- o_stream_port_ready  out  1  accept; high whenever not in reset
- o_filt_port_link  out  1  registered link
- o_filt_port_speed  out  2  registered speed
- o_filt_port_axi_data  out  DW+1  data; bit DW always 0
- o_filt_axi_data_keep  out  DW/8  keep
- o_filt_axi_data_valid  out  1  beat valid
- o_filt_axi_data_last  out  1  last beat
- i_filt_port_ready  in  1  downstream ready
- o_crc_drop_cnt  out  16  frames dropped for crcerr, saturating
- o_ovf_drop_cnt  out  16  frames dropped for overflow or link-down abort, saturating

## Operation
- Buffer: FIFO_DEPTH × (DW + DW/8 + 1) array holding data without the crcerr bit, keep, and last. The array has an asynchronous read port.
- Pointers are AW+1 bits each: wr_ptr, commit_ptr and rd_ptr.
  - full = (wr_ptr − rd_ptr == FIFO_DEPTH)
  - committed data present = (rd_ptr ≠ commit_ptr)
- Write FSM states:
  - IDLE: a valid beat writes to the array and sets err = crcerr. If last is also set, go to COMMIT processing directly; otherwise go to WRITE.
  - WRITE: each valid beat writes to the array and ORs crcerr into err. On the last beat:
    - if err (including this beat) is clear, commit_ptr ← wr_ptr+1;
    - otherwise wr_ptr ← commit_ptr and o_crc_drop_cnt +1.
    - Then go to IDLE.
  - DISCARD: beats are accepted but not written. On the last beat, wr_ptr ← commit_ptr, o_ovf_drop_cnt +1, then go to IDLE.
- Overflow: a valid beat arriving while full, in IDLE or WRITE, is not written and the FSM goes to DISCARD. If that beat is also last, the rewind and count happen immediately and the FSM stays in IDLE.
- Link-down: if i_stream_port_link is 0 while in WRITE or DISCARD, wr_ptr ← commit_ptr, o_ovf_drop_cnt +1, go to IDLE. This takes priority over a coincident beat. Valid beats in IDLE with link 0 are ignored.
- Read side: one output register. It loads array[rd_ptr] and rd_ptr +1 when committed data is present and (!o_filt_axi_data_valid || i_filt_port_ready). Otherwise valid clears on handshake.
- Committed frames are never dropped. Output order equals input order of good frames.
- Counters hold at 16'hFFFF.

## Timing
- Reset values: all outputs 0, including o_stream_port_ready. All pointers 0, FSM in IDLE, counters 0.
- o_stream_port_ready goes high on the first clock edge after reset release and stays high.
- Link and speed outputs are registered with one cycle of delay.
- Latency: the first beat of a good frame appears on o_filt_* (valid high) the edge after the edge that accepted its last beat. Example: last accepted at edge N, output valid after edge N+1.
- Throughput: one beat per cycle in and out. Commit and output-register load may happen on the same edge.
- While o_filt_axi_data_valid=1 and i_filt_port_ready=0, all o_filt_* outputs hold stable.
- Reset mid-operation clears everything immediately. Partial and committed frames are lost and are not counted.
- A frame larger than FIFO_DEPTH beats is always dropped as overflow.

## Test plan
- Good 4-beat frame, keep 4'hF×3 then 4'h3, crcerr 0, ready 1 → identical 4 beats out, valid rises 1 edge after the last input edge, bit DW = 0, both counters 0.
- 4-beat frame with crcerr=1 on beat 2 only, followed by a good 2-beat frame → only the 2-beat frame appears, o_crc_drop_cnt = 1.
- FIFO_DEPTH=16, i_filt_port_ready=0, 20-beat frame → no output, o_ovf_drop_cnt = 1. Then a good 3-beat frame with ready=1 → the 3 beats are output.
- Good frame A followed by a frame with link dropped at beat 3 → A output intact, o_ovf_drop_cnt = 1, no partial beats output.
- Three back-to-back good frames with i_filt_port_ready toggled 1,0,1,0 → all beats in order, data held stable during ready=0, no loss.
- Assert i_rst low during beat 2 of a frame → all outputs 0 immediately. After release, a good frame passes and counters start from 0.
